// File: rtl/filt_mac_mc.sv
// Multichannel time-multiplexed serial-MAC FIR filter: one multiplier and one
// coefficient set shared by gp_nchan delay lines, valid/ready in, tagged strobe out.
module filt_mac_mc #(
    parameter int gp_inp_width    = 16,
    parameter int gp_coeff_width  = 16,
    parameter int gp_coeff_length = 16,
    parameter int gp_symm         = 0,
    parameter int gp_nchan        = 4,
    parameter int gp_oup_width    = 16,
    parameter int gp_oup_shift    = 0,
    localparam int C    = (gp_symm != 0) ? (gp_coeff_length + 1) / 2 : gp_coeff_length,
    localparam int CH_W = (gp_nchan > 1) ? $clog2(gp_nchan) : 1,
    localparam int CA_W = (C > 1) ? $clog2(C) : 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_ena,
    input  logic [gp_inp_width-1:0]   i_data,
    input  logic [CH_W-1:0]           i_chan,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic                      i_coeff_we,
    input  logic [CA_W-1:0]           i_coeff_addr,
    input  logic [gp_coeff_width-1:0] i_coeff_data,
    output logic [gp_oup_width-1:0]   o_data,
    output logic [CH_W-1:0]           o_chan,
    output logic                      o_valid
);
    localparam int W     = gp_inp_width;
    localparam int CW    = gp_coeff_width;
    localparam int L     = gp_coeff_length;
    localparam int O     = gp_oup_width;
    localparam int LI_W  = $clog2(L);
    localparam int ACC_W = W + CW + $clog2(L) + 1;
    localparam int SW    = (ACC_W > O) ? ACC_W : O;
    localparam int MID   = (L - 1) / 2;
    localparam bit HAS_MID = (gp_symm != 0) && (L % 2 == 1);
    localparam logic signed [SW-1:0] OMAX = SW'({1'b0, {(O-1){1'b1}}});
    localparam logic signed [SW-1:0] OMIN = ~OMAX;

    typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_OUT} state_t;

    state_t                   state;
    logic [CA_W-1:0]          k;
    logic [CH_W-1:0]          chan_q;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_nxt;
    logic [C-1:0][CW-1:0]     coeff;
    logic [L-1:0][W-1:0]      line [gp_nchan];
    logic [L-1:0][W-1:0]      cur_line;
    logic [LI_W-1:0]          idx_lo;
    logic [LI_W-1:0]          idx_hi;
    logic signed [W-1:0]      x_lo;
    logic signed [W-1:0]      x_hi;
    logic signed [W:0]        pre;
    logic signed [CW-1:0]     h_k;
    logic signed [W+CW:0]     prod;
    logic signed [SW-1:0]     shv;
    logic [O-1:0]             sat_val;
    logic                     hs;
    logic                     chan_ok;
    logic                     addr_ok;

    assign o_ready = (state == ST_IDLE) && i_ena && !i_rst;
    assign hs      = i_valid && o_ready;
    assign chan_ok = {1'b0, i_chan} < (CH_W+1)'(gp_nchan);
    assign addr_ok = {1'b0, i_coeff_addr} < (CA_W+1)'(C);

    // Only the addressed channel shifts; out-of-range channels are swallowed.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int c = 0; c < gp_nchan; c++) line[c] <= '0;
        end else if (hs && chan_ok) begin
            line[i_chan] <= {line[i_chan][L-2:0], i_data};
        end
    end

    assign cur_line = line[chan_q];
    assign idx_lo   = LI_W'(k);
    assign idx_hi   = LI_W'(L - 1) - idx_lo;
    assign x_lo     = cur_line[idx_lo];
    assign x_hi     = cur_line[idx_hi];
    assign h_k      = coeff[k];

    // Symmetric mode folds the mirrored tap in; the odd-length centre tap stands alone.
    always_comb begin
        pre = (W+1)'(x_lo);
        if (gp_symm != 0 && !(HAS_MID && k == CA_W'(MID)))
            pre = (W+1)'(x_lo) + (W+1)'(x_hi);
    end

    assign prod    = (W+CW+1)'(pre) * (W+CW+1)'(h_k);
    assign acc_nxt = acc + ACC_W'(prod);
    assign shv     = SW'(acc_nxt) >>> gp_oup_shift;

    always_comb begin
        if (shv > OMAX)      sat_val = OMAX[O-1:0];
        else if (shv < OMIN) sat_val = OMIN[O-1:0];
        else                 sat_val = shv[O-1:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            k       <= '0;
            chan_q  <= '0;
            acc     <= '0;
            coeff   <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_chan  <= '0;
        end else if (i_ena) begin
            if (state == ST_IDLE && i_coeff_we && addr_ok)
                coeff[i_coeff_addr] <= i_coeff_data;
            case (state)
                ST_IDLE: begin
                    if (hs && chan_ok) begin
                        chan_q <= i_chan;
                        acc    <= '0;
                        k      <= '0;
                        state  <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    acc <= acc_nxt;
                    k   <= k + CA_W'(1);
                    // Final product folds straight into the registered output.
                    if (k == CA_W'(C - 1)) begin
                        state   <= ST_OUT;
                        o_valid <= 1'b1;
                        o_data  <= sat_val;
                        o_chan  <= chan_q;
                    end
                end
                ST_OUT: begin
                    o_valid <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
